// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two WIDTH-bit operands with one 4-bit adder, one nibble per cycle, LSB first.
// Optional macro NIBBLE_SERIAL_ADDER_SUB_EN adds a sub_i port that selects a - b.
//------------------------------------------------------------------------------
// Module   : nibble_serial_adder (with fourBitAdder_TwoByTwo nibble adder)
// Brief    : Multi-cycle wide adder sequencer, registered carry between nibbles
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fourBitAdder_TwoByTwo (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic             sub_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int N    = WIDTH / 4;
  localparam int IDXW = $clog2(N);
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, s_q, s_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [3:0]       add_s;
  logic             add_cout;

  // b_q holds the effective B so the overflow rule sees the inverted operand on subtract
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  assign b_eff   = sub_i ? ~b_i : b_i;
  assign cin_eff = sub_i ? 1'b1 : cin_i;
`else
  assign b_eff   = b_i;
  assign cin_eff = cin_i;
`endif

  fourBitAdder_TwoByTwo u_nibble_add (
    .a    (a_q[{idx_q, 2'b00} +: 4]),
    .b    (b_q[{idx_q, 2'b00} +: 4]),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start_i) state_d = RUN;
      end
      RUN: begin
        acc_d[{idx_q, 2'b00} +: 4] = add_s;
        carry_d = add_cout;
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = DONE;
          s_d     = {add_s, acc_q[WIDTH-5:0]};
          cout_d  = add_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_s[3] != a_q[WIDTH-1]);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = start_i ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (start_i && (state_q != RUN)) begin
      a_d     = a_i;
      b_d     = b_eff;
      carry_d = cin_eff;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o = (state_q == RUN);
  assign done_o = (state_q == DONE);
  assign s_o    = s_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule

`default_nettype wire

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder sequencer that drives one fourBitAdder_TwoByTwo instance (ports a, b, cin, s, cout) with successive 4-bit operand slices, LSB nibble first.
- Registers the inter-nibble carry and assembles the WIDTH-bit sum.
- Sits directly upstream of the 4-bit adder: it feeds the adder and consumes its result.
- Lets the datapath add wide operands with a single 4-bit adder in the hardware.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- N (local), WIDTH/4, number of nibble steps.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while nibble steps are in progress
- done  output  1  one-cycle pulse; s/cout/ovf valid from this cycle
- s  output  WIDTH  registered sum
- cout  output  1  registered carry out of MSB nibble
- ovf  output  1  registered two's-complement overflow

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; busy=0, done=0, s=0, cout=0, ovf=0; index and carry registers cleared. Reset wins over every other input.
- Reset mid-RUN aborts the operation: partial sum is discarded, s is forced to 0, and no done pulse is produced.
- FSM states:
  - IDLE: busy=0, done=0. If start=1 at an edge: latch a, b, cin into operand registers, set idx=0, carry=cin, go to RUN.
  - RUN: busy=1. Each edge: adder inputs a=A[4*idx+3:4*idx], b=B[4*idx+3:4*idx], cin=carry. Write the adder's s into sum slice idx, carry<=adder cout, idx<=idx+1. On the edge where idx==N-1, go to DONE.
  - DONE: busy=0, done=1 for exactly this cycle. s, cout, ovf are updated at the transition into DONE. Next state is IDLE, unless start=1, in which case it is RUN with new operands latched (back-to-back operation).
- Latency: start accepted at edge k; nibble steps happen at edges k+1..k+N; done is high during the cycle following edge k+N. Throughput is one result per N+1 cycles.
- start while busy=1 is ignored; operand registers are not disturbed.
- Changes to a/b/cin after acceptance have no effect on the result.
- s, cout, ovf hold their last values in IDLE until the next DONE transition.
- Sum slices are written into an internal register during RUN. Output s updates only at the DONE transition, so a partial sum is never visible on s.
- Arithmetic: {cout,s} = A + B + cin, modulo 2^(WIDTH+1).
- ovf = (A[WIDTH-1] == B[WIDTH-1]) && (s[WIDTH-1] != A[WIDTH-1]), using the effective B.
- idx counter is ceil(log2(N)) bits wide and wraps to 0 after N-1.
- Carry ripple across all nibbles, e.g. 0xFFFF+1, must propagate correctly through the carry register.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), captured with the operands on an accepted start.
  - sub=1: effective B = ~b and the initial carry is forced to 1, with cin ignored, giving s = a - b.
  - cout = 1 means no borrow.
  - ovf uses the inverted B.
- When undefined: no sub port, and the block is pure addition as described above.

Test Plan (WIDTH=16):
- a=0x1234, b=0x4321, cin=0, start pulse at edge k -> busy high for 4 cycles, done in cycle after edge k+4, s=0x5555, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, cout=1, ovf=0. Also a=0xFFFF, b=0x0000, cin=1 -> s=0x0000, cout=1.
- a=0x7FFF, b=0x0001 -> s=0x8000, cout=0, ovf=1. Also a=0x8000, b=0x8000 -> s=0x0000, cout=1, ovf=1.
- Start 0x0001+0x0001, then hold start=1 with a=0xAAAA during RUN -> start ignored, done once with s=0x0002. With start=1 in the DONE cycle, a second operation launches back-to-back and busy rises next cycle.
- Start 0x1111+0x2222, assert rst after 2 nibble steps -> next cycle busy=0, done=0, s=0, cout=0, and no done pulse follows. A subsequent 0x0003+0x0004 gives s=0x0007.
- With NIBBLE_SERIAL_ADDER_SUB_EN: a=0x0005, b=0x0007, sub=1 -> s=0xFFFE, cout=0, ovf=0. a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, cout=1, ovf=1.
